image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written; SHALL be a multiple of 4.
REQ-002 Parameter NUM_BYTES, default 65536: bytes per image (256x256 8-bit pixels); SHALL be a multiple of 4 and at least 4.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  one-cycle request to begin loading an image.
REQ-006 ABORT  input  1  synchronous cancel of the current load.
REQ-007 IN_VALID  input  1  IN_DATA holds a valid pixel byte.
REQ-008 IN_DATA  input  8  pixel byte.
REQ-009 IN_READY  output  1  loader accepts a byte this cycle.
REQ-010 MEM_WE  output  1  data-memory write strobe, one cycle per word.
REQ-011 MEM_ADDR  output  32  byte address of the word being written.
REQ-012 MEM_WD  output  32  packed word being written.
REQ-013 BUSY  output  1  load in progress; holds the processor pipeline.
REQ-014 DONE  output  1  image completely written.
REQ-015 CHECKSUM  output  8  byte sum; present only with IMAGE_LOADER_CHECKSUM_EN.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DRAIN and FINISHED.
REQ-017 IDLE: START=1 -> LOAD; clear byte counter, lane index and word index.
REQ-018 IN_READY SHALL equal (state==LOAD); a byte is accepted when IN_VALID and IN_READY are both 1.
REQ-019 Accepted bytes SHALL be packed little-endian: 1st byte to bits [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-020 The cycle after the 4th byte of a word is accepted, MEM_WE SHALL be 1 for exactly one cycle, with MEM_WD = packed word and MEM_ADDR = BASE_ADDR + 4*word_index; word_index then increments.
REQ-021 MEM_ADDR and MEM_WD SHALL hold their last values while MEM_WE=0.
REQ-022 Acceptance of byte NUM_BYTES-1 (0-based) -> DRAIN; the final MEM_WE is asserted during DRAIN, then -> FINISHED.
REQ-023 FINISHED: DONE=1 until START; START -> LOAD with counters cleared; DONE falls in the same cycle.
REQ-024 BUSY SHALL be 1 in LOAD and DRAIN, 0 otherwise.
REQ-025 START in LOAD or DRAIN SHALL be ignored.
REQ-026 ABORT in LOAD -> IDLE next cycle; the partial word is discarded and no MEM_WE is issued for it; ABORT has priority over a simultaneous byte acceptance.
REQ-027 ABORT in DRAIN SHALL NOT suppress the final write; ABORT in IDLE or FINISHED has no effect.
REQ-028 ABORT and START together in IDLE or FINISHED: ABORT wins; state stays or returns to IDLE.
REQ-029 Counters SHALL be wide enough for NUM_BYTES with no wrap-around within one image.

Reset
REQ-030 RST_N=0 SHALL immediately force state IDLE and clear all counters and outputs: IN_READY, MEM_WE, BUSY, DONE = 0; MEM_ADDR, MEM_WD, CHECKSUM = 0.
REQ-031 Reset during LOAD or DRAIN SHALL abandon the image without issuing any further MEM_WE.

Configuration
REQ-032 With IMAGE_LOADER_CHECKSUM_EN defined, CHECKSUM SHALL equal the modulo-256 sum of all bytes accepted since the last START. It SHALL be cleared on START, updated on each acceptance, and held in FINISHED.
REQ-033 Without IMAGE_LOADER_CHECKSUM_EN, the CHECKSUM port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-034 NUM_BYTES=8, BASE_ADDR=0x100; START, then bytes 01..08 on consecutive cycles -> MEM_WE with 0x100/0x04030201, then 0x104/0x08070605; DONE=1 two cycles after byte 08; CHECKSUM=0x24.
REQ-035 IN_VALID toggled 1,0,1,0 -> the same words and addresses as REQ-034; IN_READY stays 1 until the last byte is accepted.
REQ-036 ABORT asserted with byte 3 of word 0 -> no MEM_WE; IDLE; BUSY=0; a following START reloads from 0x100.
REQ-037 RST_N pulled low mid-word 1 -> all outputs 0 at once; no write to 0x104 appears.
REQ-038 START while BUSY=1 -> ignored; word indices continue unchanged; START in FINISHED -> DONE=0 and the load restarts at BASE_ADDR.
REQ-039 Bytes FF,FF,FF,FF,01,00,00,00 with NUM_BYTES=8 -> CHECKSUM=0xFD (modulo wrap); MEM_WD values 0xFFFFFFFF and 0x00000001.

Source files
------------

// File: rtl/image_loader.sv
// rtl/image_loader.sv - streams pixel bytes into 32-bit little-endian memory words (optional IMAGE_LOADER_CHECKSUM_EN)
module image_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        done
`ifdef IMAGE_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  // One spare bit on each counter so the final increment never wraps.
  localparam int CW = $clog2(NUM_BYTES) + 1;
  localparam int WW = $clog2(NUM_BYTES / 4) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISHED} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   byte_cnt;
  logic [WW-1:0]   word_idx;
  logic [23:0]     pack;
  logic            accept;
  logic            start_load;
  logic [31:0]     word_off;

  assign word_off = 32'(word_idx) << 2;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status outputs; abort always beats a byte or a start.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    start_load = 1'b0;
    case (state)
      IDLE: begin
        start_load = start && !abort;
        if (start_load) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid && !abort;
        if (abort)                             state_next = IDLE;
        else if (accept && byte_cnt == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = FINISHED;
      end
      FINISHED: begin
        done       = 1'b1;
        start_load = start && !abort;
        if (start && abort)  state_next = IDLE;
        else if (start_load) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte packing and the registered one-cycle memory write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word_idx <= '0;
      pack     <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_load) begin
        byte_cnt <= '0;
        word_idx <= '0;
        pack     <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + CW'(1);
        case (byte_cnt[1:0])
          2'd0: pack[7:0]   <= in_data;
          2'd1: pack[15:8]  <= in_data;
          2'd2: pack[23:16] <= in_data;
          default: begin
            mem_we   <= 1'b1;
            mem_wd   <= {in_data, pack};
            mem_addr <= BASE_ADDR + word_off;
            word_idx <= word_idx + WW'(1);
          end
        endcase
      end
    end
  end

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running modulo-256 sum of accepted bytes, restarted by each start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          csum <= '0;
    else if (start_load) csum <= '0;
    else if (accept)     csum <= csum + in_data;
  end

  assign checksum = csum;
`endif

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - directed vector bench for image_loader
module tb_image_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  int asserts = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  image_loader #(.BASE_ADDR(32'h0000_0100), .NUM_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .busy(busy), .done(done)
`ifdef IMAGE_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

`ifndef IMAGE_LOADER_CHECKSUM_EN
  assign checksum = 8'h00;
`endif

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wd);
    end
  end

  typedef struct {
    logic        s, a, v;
    logic [7:0]  d;
    logic        rdy, we, bsy, dn;
    logic [31:0] addr, wd;
    logic [7:0]  cs;
  } vec_t;

  vec_t vec[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cs(input string name, input logic [7:0] exp);
`ifdef IMAGE_LOADER_CHECKSUM_EN
    check(name, {24'h0, checksum}, {24'h0, exp});
`else
    if (exp === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic drive(input logic s, input logic a, input logic v, input logic [7:0] d);
    start = s; abort = a; in_valid = v; in_data = d;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 10 && !done; k++) drive(0, 0, 0, 8'h00);
    check(name, {31'h0, done}, 32'h1);
  endtask

  task automatic check_writes(input string name, input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1);
    check({name, "_count"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({name, "_a0"}, wr_addr[0], a0);
      check({name, "_d0"}, wr_data[0], d0);
      check({name, "_a1"}, wr_addr[1], a1);
      check({name, "_d1"}, wr_data[1], d1);
    end
  endtask

  initial begin
    //         s  a  v  d       rdy we bsy dn addr          wd            cs
    vec[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 32'h000, 32'h00000000, 8'h00};
    vec[1]  = '{0, 0, 1, 8'h01, 1, 0, 1, 0, 32'h000, 32'h00000000, 8'h00};
    vec[2]  = '{0, 0, 1, 8'h02, 1, 0, 1, 0, 32'h000, 32'h00000000, 8'h01};
    vec[3]  = '{0, 0, 1, 8'h03, 1, 0, 1, 0, 32'h000, 32'h00000000, 8'h03};
    vec[4]  = '{0, 0, 1, 8'h04, 1, 0, 1, 0, 32'h000, 32'h00000000, 8'h06};
    vec[5]  = '{0, 0, 1, 8'h05, 1, 1, 1, 0, 32'h100, 32'h04030201, 8'h0A};
    vec[6]  = '{0, 0, 1, 8'h06, 1, 0, 1, 0, 32'h100, 32'h04030201, 8'h0F};
    vec[7]  = '{0, 0, 1, 8'h07, 1, 0, 1, 0, 32'h100, 32'h04030201, 8'h15};
    vec[8]  = '{0, 0, 1, 8'h08, 1, 0, 1, 0, 32'h100, 32'h04030201, 8'h1C};
    vec[9]  = '{0, 1, 0, 8'h00, 0, 1, 1, 0, 32'h104, 32'h08070605, 8'h24};
    vec[10] = '{0, 1, 0, 8'h00, 0, 0, 0, 1, 32'h104, 32'h08070605, 8'h24};
    vec[11] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 32'h104, 32'h08070605, 8'h24};
    vec[12] = '{1, 0, 1, 8'h11, 1, 0, 1, 0, 32'h104, 32'h08070605, 8'h00};
    vec[13] = '{1, 0, 1, 8'h22, 1, 0, 1, 0, 32'h104, 32'h08070605, 8'h11};
    vec[14] = '{0, 0, 1, 8'h33, 1, 0, 1, 0, 32'h104, 32'h08070605, 8'h33};
    vec[15] = '{0, 0, 1, 8'h44, 1, 0, 1, 0, 32'h104, 32'h08070605, 8'h66};
    vec[16] = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 32'h100, 32'h44332211, 8'hAA};
    vec[17] = '{0, 0, 0, 8'h00, 1, 0, 1, 0, 32'h100, 32'h44332211, 8'hAA};

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      check($sformatf("v%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vec[i].rdy});
      check($sformatf("v%0d_mem_we", i),   {31'h0, mem_we},   {31'h0, vec[i].we});
      check($sformatf("v%0d_busy", i),     {31'h0, busy},     {31'h0, vec[i].bsy});
      check($sformatf("v%0d_done", i),     {31'h0, done},     {31'h0, vec[i].dn});
      check($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].addr);
      check($sformatf("v%0d_mem_wd", i),   mem_wd,   vec[i].wd);
      check_cs($sformatf("v%0d_checksum", i), vec[i].cs);
      drive(vec[i].s, vec[i].a, vec[i].v, vec[i].d);
    end

    // Reset in the middle of word 1: everything drops at once, no later write.
    drive(0, 0, 1, 8'h55);
    start = 0; abort = 0; in_valid = 0; in_data = 8'h00;
    wr_addr.delete();
    wr_data.delete();
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_mem_we",   {31'h0, mem_we},   32'h0);
    check("rst_busy",     {31'h0, busy},     32'h0);
    check("rst_done",     {31'h0, done},     32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd",   mem_wd,   32'h0);
    check_cs("rst_checksum", 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 8'h00);
    check("rst_no_write", wr_addr.size(), 0);

    // Abort together with byte 3 of word 0.
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h01);
    drive(0, 0, 1, 8'h02);
    drive(0, 1, 1, 8'h03);
    check("abort_busy",     {31'h0, busy},     32'h0);
    check("abort_in_ready", {31'h0, in_ready}, 32'h0);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 8'h00);
    check("abort_no_write", wr_addr.size(), 0);
    check("abort_done",     {31'h0, done}, 32'h0);

    // Reload with in_valid toggling 1,0,1,0.
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("toggle%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
      drive(0, 0, (i % 2) == 0, 8'((i / 2) + 1));
    end
    wait_done("toggle_done");
    check_writes("toggle_wr", 32'h100, 32'h04030201, 32'h104, 32'h08070605);
    check_cs("toggle_checksum", 8'h24);

    // Start and abort together in FINISHED returns to IDLE.
    drive(1, 1, 0, 8'h00);
    check("sa_done", {31'h0, done}, 32'h0);
    check("sa_busy", {31'h0, busy}, 32'h0);

    // Checksum wrap-around image.
    wr_addr.delete();
    wr_data.delete();
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'hFF);
    drive(0, 0, 1, 8'hFF);
    drive(0, 0, 1, 8'hFF);
    drive(0, 0, 1, 8'hFF);
    drive(0, 0, 1, 8'h01);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 1, 8'h00);
    wait_done("wrap_done");
    check_writes("wrap_wr", 32'h100, 32'hFFFFFFFF, 32'h104, 32'h00000001);
    check_cs("wrap_checksum", 8'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
